// File: rtl/piso_10bits_cond.sv
// piso_10bits_cond
// Parallel-in, serial-out transmitter for the 10-bit serial link.
// Words arrive over a valid/ready handshake into a one-word holding
// register and are shifted out LSB first in back-to-back frames. Frames
// with no pending word carry IDLE_WORD so the far end always sees framed
// traffic.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every
// frame (frames become WIDTH+1 bits long, idle frames included).

module piso_10bits_cond #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] IDLE_WORD = 10'h17C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Pdata,
    input  logic             Pvalid,
    output logic             Pready,
    output logic             Sdata,
    output logic             Sframe,
    output logic             Sdatafrm
);

`ifdef PISO_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    // Index of the last bit in a frame; the counter wraps after it.
    localparam int LAST = SW - 1;
    localparam int CW   = (SW > 1) ? $clog2(SW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

    // The two state bits are {data_frm, hold_full}.
    typedef enum logic [1:0] {
        IDLE_TX      = 2'b00,
        IDLE_TX_PEND = 2'b01,
        DATA_TX      = 2'b10,
        DATA_TX_PEND = 2'b11
    } tx_state_t;

    tx_state_t        state;
    logic [SW-1:0]    shreg;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic             data_frm;
    logic             boundary;
    logic             accept;

    // Builds the full frame image for a payload word, parity on top if enabled.
    function automatic logic [SW-1:0] load_frame(input logic [WIDTH-1:0] w);
`ifdef PISO_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    assign data_frm  = state[1];
    assign hold_full = state[0];
    assign boundary  = (bit_cnt == LAST_CNT);
    assign accept    = Pvalid && !hold_full;

    assign Sdata    = shreg[0];
    assign Sframe   = (bit_cnt == '0);
    assign Sdatafrm = data_frm;
    assign Pready   = ~hold_full;

    // Shifter, bit counter and the hold/data-frame state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= load_frame(IDLE_WORD);
            bit_cnt <= '0;
            state   <= IDLE_TX;
        end else begin
            if (boundary) begin
                bit_cnt <= '0;
                shreg   <= hold_full ? load_frame(hold_reg) : load_frame(IDLE_WORD);
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
                shreg   <= shreg >> 1;
            end

            case (state)
                IDLE_TX:      state <= accept ? IDLE_TX_PEND : IDLE_TX;
                IDLE_TX_PEND: state <= boundary ? DATA_TX : IDLE_TX_PEND;
                DATA_TX: begin
                    if (boundary) state <= accept ? IDLE_TX_PEND : IDLE_TX;
                    else          state <= accept ? DATA_TX_PEND : DATA_TX;
                end
                DATA_TX_PEND: state <= boundary ? DATA_TX : DATA_TX_PEND;
                default:      state <= IDLE_TX;
            endcase
        end
    end

    // Captures an accepted word; only possible while the holding register is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_reg <= Pdata;
        end
    end

endmodule

// File: tb/tb_piso_10bits_cond.sv
// tb_piso_10bits_cond
// Self-checking bench for piso_10bits_cond: a constant vector table for the
// reset/idle pattern, hand-written corner sequences and randomized traffic,
// all compared against a frame-level reference model. PISO_PARITY_EN adds
// the parity-frame sequence.

module tb_piso_10bits_cond;

    localparam int               WIDTH     = 10;
    localparam logic [WIDTH-1:0] IDLE_WORD = 10'h17C;
`ifdef PISO_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int NTBL = 33;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] Pdata;
    logic             Pvalid;
    logic             Pready;
    logic             Sdata;
    logic             Sframe;
    logic             Sdatafrm;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    // Reference model: the frame on the wire, the bit position and a one-deep queue.
    logic [WIDTH-1:0] m_word;
    bit               m_data;
    int               m_pos;
    logic [WIDTH-1:0] m_pend[$];

    // Receiver-side capture of data frames.
    logic [WIDTH-1:0] cap_words[$];
    int               data_starts[$];
    logic [WIDTH-1:0] cap_buf;
    int               cap_idx;
    bit               cap_on = 1'b0;

    typedef struct {
        logic             rst;
        logic             pvalid;
        logic [WIDTH-1:0] pdata;
        logic             e_sdata;
        logic             e_sframe;
        logic             e_sdatafrm;
        logic             e_pready;
    } vec_t;

    vec_t tbl[NTBL];
    int   idle_seq[10] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 0};

    logic [WIDTH-1:0] src[3] = '{10'h001, 10'h3FF, 10'h155};
    int               acc_times[$];
    int               si;
    int               guard;
    bit               take;

    piso_10bits_cond dut (
        .clk      (clk),
        .reset    (reset),
        .Pdata    (Pdata),
        .Pvalid   (Pvalid),
        .Pready   (Pready),
        .Sdata    (Sdata),
        .Sframe   (Sframe),
        .Sdatafrm (Sdatafrm)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something upstream never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic model_bit();
        if (m_pos < WIDTH) return m_word[m_pos];
        return ^m_word;
    endfunction

    task automatic model_step();
        bit acc;
        if (reset) begin
            m_word = IDLE_WORD;
            m_data = 1'b0;
            m_pos  = 0;
            m_pend.delete();
        end else begin
            acc = Pvalid && (m_pend.size() == 0);
            if (m_pos == FL - 1) begin
                m_pos = 0;
                if (m_pend.size() > 0) begin
                    m_word = m_pend.pop_front();
                    m_data = 1'b1;
                end else begin
                    m_word = IDLE_WORD;
                    m_data = 1'b0;
                end
            end else begin
                m_pos++;
            end
            if (acc) m_pend.push_back(Pdata);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s @%0t: got %b, want %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check1({tag, ".Sdata"},    Sdata,    model_bit());
        check1({tag, ".Sframe"},   Sframe,   (m_pos == 0));
        check1({tag, ".Sdatafrm"}, Sdatafrm, m_data);
        check1({tag, ".Pready"},   Pready,   (m_pend.size() == 0));
    endtask

    // Drives one cycle of inputs, advances the model, samples 1 ns after the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] d);
        reset  = r;
        Pvalid = v;
        Pdata  = d;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (Sframe && Sdatafrm) begin
            cap_on  = 1'b1;
            cap_idx = 0;
            cap_buf = '0;
            data_starts.push_back(cyc);
        end
        if (cap_on) begin
            cap_buf[cap_idx] = Sdata;
            cap_idx++;
            if (cap_idx == WIDTH) begin
                cap_words.push_back(cap_buf);
                cap_on = 1'b0;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        Pvalid = 1'b0;
        Pdata  = '0;
        m_word = IDLE_WORD;
        m_data = 1'b0;
        m_pos  = 0;

        // Table: reset held 3 cycles, then 30 idle cycles.
        for (int i = 0; i < 3; i++)
            tbl[i] = '{1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 1; k <= 30; k++)
            tbl[2 + k] = '{1'b0, 1'b0, '0,
                           ((k % FL) < WIDTH) ? 1'(idle_seq[k % FL]) : 1'b0,
                           ((k % FL) == 0), 1'b0, 1'b1};

        for (int i = 0; i < NTBL; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].pvalid, tbl[i].pdata);
            check1("tbl.Sdata",    Sdata,    tbl[i].e_sdata);
            check1("tbl.Sframe",   Sframe,   tbl[i].e_sframe);
            check1("tbl.Sdatafrm", Sdatafrm, tbl[i].e_sdatafrm);
            check1("tbl.Pready",   Pready,   tbl[i].e_pready);
        end

        // Single word accepted in the middle of an idle frame.
        cap_words.delete();
        repeat (4) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("idle"); end
        applyStimulus(1'b0, 1'b1, 10'h2A5);
        checkOutput("acc2A5");
        check1("single.pready_low", Pready, 1'b0);
        repeat (3 * FL) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("single"); end
        check_int("single.frames", cap_words.size(), 1);
        if (cap_words.size() > 0) check_word("single.word", cap_words[0], 10'h2A5);

        // Source streams three words with Pvalid held high.
        cap_words.delete();
        data_starts.delete();
        si    = 0;
        guard = 0;
        while (si < 3 && guard < 100) begin
            take = Pready;
            applyStimulus(1'b0, 1'b1, src[si]);
            checkOutput("stream");
            if (take) begin acc_times.push_back(cyc); si++; end
            guard++;
        end
        check_int("stream.all_accepted", si, 3);
        repeat (4 * FL) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("stream.tail"); end
        check_int("stream.frames", cap_words.size(), 3);
        for (int i = 0; i < 3 && i < cap_words.size(); i++)
            check_word("stream.word", cap_words[i], src[i]);
        if (data_starts.size() >= 3) begin
            check_int("stream.gap01", data_starts[1] - data_starts[0], FL);
            check_int("stream.gap12", data_starts[2] - data_starts[1], FL);
        end
        if (acc_times.size() >= 3)
            check_int("stream.accept_period", acc_times[2] - acc_times[1], FL);

        // Word offered exactly on the boundary edge with the hold register empty.
        guard = 0;
        while (!(m_pos == FL - 1 && m_pend.size() == 0 && !m_data) && guard < 40) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("align");
            guard++;
        end
        check_int("bnd.aligned", m_pos, FL - 1);
        applyStimulus(1'b0, 1'b1, 10'h0F0);
        checkOutput("bnd.acc");
        check1("bnd.idle_Sframe",   Sframe,   1'b1);
        check1("bnd.idle_Sdatafrm", Sdatafrm, 1'b0);
        check1("bnd.Pready",        Pready,   1'b0);
        repeat (FL) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("bnd"); end
        check1("bnd.data_Sframe",   Sframe,   1'b1);
        check1("bnd.data_Sdatafrm", Sdatafrm, 1'b1);
        repeat (FL + 2) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("bnd.tail"); end

        // Reset at bit 5 of a data frame while a second word is pending.
        applyStimulus(1'b0, 1'b1, 10'h3C3);
        checkOutput("rst.accA");
        guard = 0;
        while (!(Sframe && Sdatafrm) && guard < 3 * FL) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("rst.wait");
            guard++;
        end
        check1("rst.data_start", Sframe && Sdatafrm, 1'b1);
        applyStimulus(1'b0, 1'b1, 10'h2DB);
        checkOutput("rst.accB");
        repeat (4) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("rst.mid"); end
        check_int("rst.at_bit5", m_pos, 5);
        applyStimulus(1'b1, 1'b0, '0);
        check1("rst.Sdata",    Sdata,    1'b0);
        check1("rst.Sframe",   Sframe,   1'b1);
        check1("rst.Sdatafrm", Sdatafrm, 1'b0);
        check1("rst.Pready",   Pready,   1'b1);
        cap_words.delete();
        cap_on = 1'b0;
        repeat (3 * FL) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("rst.after"); end
        check_int("rst.discarded", cap_words.size(), 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                          WIDTH'($urandom));
            checkOutput("rand");
        end

`ifdef PISO_PARITY_EN
        // Parity bit on an idle frame and on a data frame carrying 10'h007.
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("par.rst");
        applyStimulus(1'b0, 1'b1, 10'h007);
        checkOutput("par.acc");
        repeat (9) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("par.idle"); end
        check1("par.idle_parity", Sdata,  1'b0);
        check1("par.idle_bit10",  Sframe, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("par.start");
        check1("par.data_Sframe",   Sframe,   1'b1);
        check1("par.data_Sdatafrm", Sdatafrm, 1'b1);
        repeat (10) begin applyStimulus(1'b0, 1'b0, '0); checkOutput("par.data"); end
        check1("par.data_parity", Sdata,  1'b1);
        check1("par.data_bit10",  Sframe, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("par.next");
        check1("par.next_Sframe",   Sframe,   1'b1);
        check1("par.next_Sdatafrm", Sdatafrm, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
